sram_req_rsp: RTL and testbench
===============================

# sram_req_rsp

Parametrised single-port SRAM with a valid/ready request channel, byte-lane write strobes, a registered and back-pressurable read-response channel, and out-of-range address detection for non-power-of-two depths. It is the successor to the tri-state-data single-port RAM and is intended as the default on-chip buffer behind stream and bus adapters. Separate write and read data buses replace the bidirectional data port, so the block integrates without tri-states.

## Interface
- `WIDTH`, 32, data word width in bits; must be a multiple of `BYTE_WIDTH`.
- `DEPTH`, 16, number of words; any value ≥ 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `BYTE_WIDTH`, 8, bits per write-strobe lane.
- `STRB_WIDTH`, `WIDTH/BYTE_WIDTH`, number of strobe lanes.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_WIDTH`: word address.
- `req_wdata` in `WIDTH`: write data.
- `req_wstrb` in `STRB_WIDTH`: lane i writes bits `[i*BYTE_WIDTH +: BYTE_WIDTH]`.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out `WIDTH`: read data.
- `rsp_error` out 1: the read address was ≥ `DEPTH`.

## Operation
- A handshake occurs at a posedge where `req_valid && req_ready`. At most one access per cycle (single port).
- Write handshake: only lanes with a set strobe are updated. `wstrb == 0` is a legal no-op. Writes produce no response.
- Write to `addr >= DEPTH`: ignored. Memory is unchanged and no error is reported.
- Read handshake: the response register loads `memory[addr]` and `rsp_valid` is set. The read sees all earlier accepted writes.
- Read from `addr >= DEPTH`: `rsp_rdata = 0`, `rsp_error = 1`.
- `rsp_valid`, `rsp_rdata` and `rsp_error` hold stable until the posedge where `rsp_valid && rsp_ready`. At that edge they load the next read result if a read is accepted in the same cycle; otherwise `rsp_valid` clears.
- `req_ready = (state == READY) && (!rsp_valid || rsp_ready)`. This is combinational and applies to both reads and writes, so request order is preserved against a stalled response.
- States:
  - `CLEAR`: only exists with the configuration macro defined.
  - `READY`: normal operation.
- Reset values: `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0. `req_ready` = 0 in any cycle where `rst_n` is low.

## Timing
- Read latency is 1. For a read accepted at edge N, `rsp_valid` is high in cycle N+1.
- Sustained throughput is 1 access per cycle while `rsp_ready` is held high.
- `rsp_ready` low with `rsp_valid` high drops `req_ready` in the same cycle (combinational path `rsp_ready` → `req_ready`).
- Applying `rst_n` low mid-transaction drops the pending response: `rsp_valid` is 0 after the edge. Memory contents are not altered by reset itself.
- Without the macro, `req_ready` can be 1 in the first cycle after `rst_n` rises.

## Configuration
- `SRAM_REQ_RSP_CLEAR_EN` defined:
  - Reset puts the block in `CLEAR` with a clear counter of 0.
  - Each cycle in `CLEAR` writes 0 to `memory[counter]` and increments the counter.
  - After writing `DEPTH-1`, the block goes to `READY`. The clear takes `DEPTH` cycles after `rst_n` rises.
  - `req_ready` = 0 throughout `CLEAR`.
  - Reset during `CLEAR` restarts the counter at 0.
- Not defined: there is no `CLEAR` state. Memory is uninitialised (X in simulation), and the block is `READY` immediately after reset.

## Test plan
- Write `0xDEADBEEF` to addr 3 with `wstrb = 4'hF`, then read addr 3 → `rsp_valid` high one cycle after the read handshake, `rsp_rdata = 0xDEADBEEF`, `rsp_error = 0`.
- Write `0x11223344` full, then `0xAABBCCDD` with `wstrb = 4'b0101`, then read → `0x11BB33DD`.
- `DEPTH = 12`: write addr 13, then read addr 13 → `rsp_rdata = 0`, `rsp_error = 1`. Read addr 11 still returns its own contents.
- Back-to-back reads of addrs 0,1,2 with `rsp_ready` low for cycles 2–4:
  - `req_ready` = 0 while stalled, and the response holds addr 0's data.
  - After release, responses arrive in order 0,1,2 with no loss or duplication.
- With `SRAM_REQ_RSP_CLEAR_EN`, `DEPTH = 16`:
  - `req_ready` stays 0 for 16 cycles after `rst_n` rises.
  - Every read afterwards returns 0.
  - Asserting `rst_n` low at clear cycle 7 restarts the full 16-cycle clear.
- Assert reset while `rsp_valid = 1` and `rsp_ready = 0` → `rsp_valid = 0` after the edge. A subsequent read returns data written before reset.

Source files
------------

// File: rtl/sram_req_rsp.sv
// Single-port SRAM with a valid/ready request channel, byte strobes and a registered, stallable read response.
// Define SRAM_REQ_RSP_CLEAR_EN to zero the whole array after every reset before requests are accepted.
module sram_req_rsp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BYTE_WIDTH = 8,
  parameter int STRB_WIDTH = WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef SRAM_REQ_RSP_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] cnt_q;
`else
  typedef enum logic {READY} state_t;
`endif

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range;
  logic             hs;
  logic             wr_en;
  logic             rd_en;
  logic             rsp_free;
  logic [WIDTH-1:0] rd_word;

  logic             vld_p1;
  logic [WIDTH-1:0] rdata_p1;
  logic             err_p1;

  assign in_range  = {1'b0, req_addr} < DEPTH_C;
  assign rsp_free  = !vld_p1 || rsp_ready;
  assign req_ready = rst_n && (state_q == READY) && rsp_free;
  assign hs        = req_valid && req_ready;
  assign wr_en     = hs && req_write && in_range;
  assign rd_en     = hs && !req_write;

  always_comb begin
    state_d = state_q;
`ifdef SRAM_REQ_RSP_CLEAR_EN
    if (state_q == CLEAR && cnt_q == LAST_C) state_d = READY;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef SRAM_REQ_RSP_CLEAR_EN
      state_q <= CLEAR;
`else
      state_q <= READY;
`endif
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SRAM_REQ_RSP_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q == CLEAR) cnt_q <= cnt_q + 1'b1;
  end

  // Array write port: the clear sweep owns it until READY, since req_ready is low during CLEAR.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++)
        if (req_wstrb[i]) mem[req_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
`else
  // Array write port; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++)
        if (req_wstrb[i]) mem[req_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= req_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[req_addr];
  end

  // Stage p1: response register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (rsp_free) begin
      if (rd_en) begin
        vld_p1   <= 1'b1;
        rdata_p1 <= rd_word;
        err_p1   <= !in_range;
      end else begin
        vld_p1   <= 1'b0;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;
  assign rsp_error = err_p1;

endmodule

// File: tb/tb_sram_req_rsp.sv
// Directed bench for sram_req_rsp (DEPTH=12, so addresses 12..15 are out of range).
module tb_sram_req_rsp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 12;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [SW-1:0]    req_wstrb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_error;

  int checks   = 0;
  int failures = 0;

  sram_req_rsp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    #1;
    while (!req_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
`ifdef SRAM_REQ_RSP_CLEAR_EN
    begin
      int n = 0;
      #1;
      while (!req_ready && n < 100) begin
        tick();
        n++;
      end
      chk("clear_cycles", n, DEPTH);
    end
`else
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
`endif
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [SW-1:0] s);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    wait_ready("wr_ready");
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Issues a read, then checks the response one cycle after the handshake and its retirement.
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] d, input logic e);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    wait_ready("rd_ready");
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_rdata, d);
    chk({tag, "_err"}, {31'd0, rsp_error}, {31'd0, e});
    tick();
    chk({tag, "_retired"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] exp7;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    tick(); tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    release_reset();

`ifdef SRAM_REQ_RSP_CLEAR_EN
    rd("clr0", 4'd0, 32'd0, 1'b0);
    rd("clr11", 4'd11, 32'd0, 1'b0);
    // Reset at clear cycle 7 must restart the full sweep.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("clear_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0; tick();
    release_reset();
`endif

    // Full write then read-back.
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rd("full", 4'd3, 32'hDEADBEEF, 1'b0);

    // Partial strobes and a zero-strobe no-op.
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd("strb", 4'd5, 32'h11BB33DD, 1'b0);
    wr(4'd5, 32'hFFFFFFFF, 4'h0);
    rd("nostrb", 4'd5, 32'h11BB33DD, 1'b0);

    // Out-of-range address handling.
    wr(4'd11, 32'hCAFEF00D, 4'hF);
    wr(4'd13, 32'h12345678, 4'hF);
    rd("oor13", 4'd13, 32'h0, 1'b1);
    rd("top11", 4'd11, 32'hCAFEF00D, 1'b0);

    // Back-to-back reads with the response channel stalled.
    wr(4'd0, 32'h000000A0, 4'hF);
    wr(4'd1, 32'h000000A1, 4'hF);
    wr(4'd2, 32'h000000A2, 4'hF);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0;
    #1; chk("bp_ready0", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 4'd1; rsp_ready = 1'b0;
    #1;
    chk("bp_stall_ready", {31'd0, req_ready}, 32'd0);
    chk("bp_stall_data", rsp_rdata, 32'hA0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_data", rsp_rdata, 32'hA0);
      chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1; chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 4'd2;
    chk("bp_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_rsp1_data", rsp_rdata, 32'hA1);
    tick();
    req_valid = 1'b0;
    chk("bp_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_rsp2_data", rsp_rdata, 32'hA2);
    tick();
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Reset while a response is stalled.
    wr(4'd7, 32'h5A5A1234, 4'hF);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
    wait_ready("rr_ready");
    tick();
    req_valid = 1'b0;
    chk("rr_pending", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rr_dropped", {31'd0, rsp_valid}, 32'd0);
    chk("rr_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    release_reset();
`ifdef SRAM_REQ_RSP_CLEAR_EN
    exp7 = 32'h0;
`else
    exp7 = 32'h5A5A1234;
`endif
    rd("after_rst", 4'd7, exp7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
